avalon_memtest_master: RTL

//  Avalon-MM master that fills a word-addressed on-chip RAM slave with a pattern, reads every word back and compares.

---
 rtl/avalon_memtest_master.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/avalon_memtest_master.sv
// Avalon-MM RAM self-test master: fills base..base+count-1 with a pattern, reads back, counts mismatches.
// Optional MEMTEST_LFSR_PATTERN_EN selects a 32-bit Galois LFSR pattern instead of seed+i.
module avalon_memtest_master #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int ERRCNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  input  logic [DATA_W-1:0]     seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERRCNT_W-1:0]   err_count,
  output logic [ADDR_W-1:0]     first_err_addr,
  output logic [ADDR_W-1:0]     avm_address,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  avm_chipselect,
  output logic                  avm_write,
  output logic                  avm_read,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [2:0] LAT_LAST = 3'(READ_LATENCY - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_RWAIT, S_FIN} state_t;

  state_t              state, state_nx;
  logic [ADDR_W:0]     cnt, idx;
  logic [ADDR_W-1:0]   base, addr;
  logic [DATA_W-1:0]   seed_q, pat, pat_step, seed_norm;
  logic [2:0]          lat_cnt;
  logic                accept, wr_acc, rd_acc, cap, last;

`ifdef MEMTEST_LFSR_PATTERN_EN
  // DATA_W must be 32 in this mode; taps x^32+x^22+x^2+x+1
  localparam logic [DATA_W-1:0] TAPS = 32'h8020_0003;
  assign pat_step  = pat[0] ? ((pat >> 1) ^ TAPS) : (pat >> 1);
  assign seed_norm = (seed == '0) ? DATA_W'(1) : seed;
`else
  assign pat_step  = pat + DATA_W'(1);
  assign seed_norm = seed;
`endif

  assign last = (idx == (cnt - (ADDR_W+1)'(1)));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    accept    = 1'b0;
    wr_acc    = 1'b0;
    rd_acc    = 1'b0;
    cap       = 1'b0;
    avm_write = 1'b0;
    avm_read  = 1'b0;
    case (state)
      S_IDLE: begin
        // a start coinciding with the done pulse belongs to the old run and is dropped
        if (start && !done) begin
          accept   = 1'b1;
          state_nx = (word_count == '0) ? S_FIN : S_WRITE;
        end
      end
      S_WRITE: begin
        avm_write = 1'b1;
        if (!avm_waitrequest) begin
          wr_acc = 1'b1;
          if (last) state_nx = S_READ;
        end
      end
      S_READ: begin
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          rd_acc   = 1'b1;
          state_nx = S_RWAIT;
        end
      end
      S_RWAIT: begin
        if (lat_cnt == LAT_LAST) begin
          cap      = 1'b1;
          state_nx = last ? S_FIN : S_READ;
        end
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  assign busy           = (state != S_IDLE);
  assign avm_chipselect = avm_write | avm_read;
  assign avm_byteenable = {BE_W{avm_chipselect}};
  assign avm_address    = addr;
  assign avm_writedata  = pat;

  always_ff @(posedge clk) begin
    if (reset) begin
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      cnt            <= '0;
      idx            <= '0;
      base           <= '0;
      addr           <= '0;
      seed_q         <= '0;
      pat            <= '0;
      lat_cnt        <= '0;
    end else begin
      done <= (state == S_FIN);
      if (accept) begin
        base           <= base_addr;
        addr           <= base_addr;
        cnt            <= word_count;
        seed_q         <= seed_norm;
        pat            <= seed_norm;
        idx            <= '0;
        err_count      <= '0;
        first_err_addr <= '0;
        pass           <= 1'b0;
      end
      if (wr_acc) begin
        // after the last write, rewind address and pattern for the read pass
        if (last) begin
          idx  <= '0;
          addr <= base;
          pat  <= seed_q;
        end else begin
          idx  <= idx + (ADDR_W+1)'(1);
          addr <= addr + ADDR_W'(1);
          pat  <= pat_step;
        end
      end
      if (rd_acc) lat_cnt <= '0;
      else if (state == S_RWAIT && !cap) lat_cnt <= lat_cnt + 3'(1);
      if (cap) begin
        if (avm_readdata != pat) begin
          if (err_count != '1) err_count <= err_count + ERRCNT_W'(1);
          if (err_count == '0) first_err_addr <= addr;
        end
        idx  <= idx + (ADDR_W+1)'(1);
        addr <= addr + ADDR_W'(1);
        pat  <= pat_step;
      end
      if (state == S_FIN) pass <= (err_count == '0);
    end
  end

endmodule
